// File: rtl/sha_msg_pad.sv
// SHA-256 message padder: turns a stream of big-endian 32-bit message words
// into 16-word blocks (data, 0x80 marker, zero fill, 64-bit bit length),
// framed with out_first / out_last_blk for the downstream message schedule.
module sha_msg_pad #(
  parameter int unsigned BCNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [2:0]  in_bytes,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last_blk,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, DATA, PAD, ZERO, LENH, LENL, FLUSH, DONE
  } state_t;

  state_t              state, state_n;
  logic [3:0]          wcnt;
  logic [BCNT_W-1:0]   bcnt, bcnt_n;
  logic                last_r;
  logic                load, load_last, free, consume;
  logic [31:0]         load_data;
  logic [3:0]          nidx;
  logic [2:0]          nb;
  logic [63:0]         bitlen;

  assign free      = ~out_valid | out_ready;
  assign consume   = out_valid & out_ready;
  // index of the word that a load in this cycle will occupy
  assign nidx      = wcnt + {3'b000, out_valid};
  assign in_ready  = (state == DATA) & free & ~run;
  assign out_first    = out_valid & (wcnt == 4'd0);
  assign out_last_blk = out_valid & last_r;
  assign done      = (state == DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and output-register load selection
  always_comb begin
    state_n   = state;
    bcnt_n    = bcnt;
    load      = 1'b0;
    load_last = 1'b0;
    load_data = '0;
    nb        = (in_bytes >= 3'd4) ? 3'd4 : in_bytes;
    bitlen    = '0;
    bitlen[BCNT_W+2:0] = {bcnt, 3'b000};
    case (state)
      IDLE: ;
      DATA: begin
        if (in_valid && free) begin
          load = 1'b1;
          if (!in_last) begin
            load_data = in_data;
            bcnt_n    = bcnt + BCNT_W'(4);
          end else begin
            bcnt_n = bcnt + BCNT_W'(nb);
            if (nb == 3'd4) begin
              load_data = in_data;
              state_n   = PAD;
            end else begin
              // keep the first nb bytes, place the 0x80 marker right after them
              load_data = (in_data & ~(32'hFFFF_FFFF >> {nb, 3'b000}))
                        | (32'h8000_0000 >> {nb, 3'b000});
              state_n   = ZERO;
            end
          end
        end
      end
      PAD: begin
        if (free) begin
          load      = 1'b1;
          load_data = 32'h8000_0000;
          state_n   = ZERO;
        end
      end
      ZERO: begin
        if (free) begin
          if (nidx == 4'd14) state_n = LENH;
          else               load    = 1'b1;
        end
      end
      LENH: begin
        if (free) begin
          load      = 1'b1;
          load_data = bitlen[63:32];
          state_n   = LENL;
        end
      end
      LENL: begin
        if (free) begin
          load      = 1'b1;
          load_last = 1'b1;
          load_data = bitlen[31:0];
          state_n   = FLUSH;
        end
      end
      FLUSH: if (consume) state_n = DONE;
      DONE: ;
      default: state_n = IDLE;
    endcase
    if (run) begin
      state_n = DATA;
      load    = 1'b0;
    end
  end

  // Output register, consumed-word counter and byte counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      last_r    <= 1'b0;
      wcnt      <= '0;
      bcnt      <= '0;
    end else if (run) begin
      out_valid <= 1'b0;
      last_r    <= 1'b0;
      wcnt      <= '0;
      bcnt      <= '0;
    end else begin
      bcnt <= bcnt_n;
      if (consume) wcnt <= wcnt + 4'd1;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        last_r    <= load_last;
      end else if (consume) begin
        out_valid <= 1'b0;
        last_r    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha_msg_pad.sv
// Self-checking bench for sha_msg_pad: directed table, random messages with
// random stalls, reset-abort and run-abort sequences, all checked against a
// byte-level padding model.
module tb_sha_msg_pad;

  logic        clk = 1'b0;
  logic        rst, run, in_valid, in_last, out_ready;
  logic [31:0] in_data;
  logic [2:0]  in_bytes;
  logic        in_ready, out_valid, out_first, out_last_blk, done;
  logic [31:0] out_data;

  sha_msg_pad #(.BCNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last_blk(out_last_blk), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0, n_total = 0;

  typedef struct { logic [31:0] data; logic first; logic last; } oword_t;
  typedef struct { int len; bit abc; int mode; int exp_words; logic [31:0] exp_last; } vec_t;

  byte unsigned msg[$];
  oword_t       expq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: pad the byte string per SHA-256 rules, then cut into words
  function automatic void build_expected();
    byte unsigned p[$];
    logic [63:0]  bl;
    int           nw;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    expq.delete();
    nw = p.size() / 4;
    for (int w = 0; w < nw; w++) begin
      oword_t o;
      o.data  = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
      o.first = (w % 16 == 0);
      o.last  = (w == nw - 1);
      expq.push_back(o);
    end
  endfunction

  function automatic logic [31:0] word_at(int wi);
    logic [31:0] w;
    w = $urandom;
    for (int k = 0; k < 4; k++)
      if (4*wi + k < msg.size()) w[31-8*k -: 8] = msg[4*wi + k];
    return w;
  endfunction

  task automatic drive_word(input int wi, input int nw);
    in_data  = word_at(wi);
    in_last  = (wi == nw - 1);
    in_bytes = (wi == nw - 1) ? 3'(msg.size() - 4*wi) : 3'd4;
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready and input gaps
  task automatic run_msg(input int mode, input int abort_after,
                         output int nwords, output logic [31:0] lastw);
    int          nw, wi, consumed, cyc;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [3:0]  pat;
    oword_t      e;
    pat = 4'b1001;
    nw = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
    build_expected();
    wi = 0; consumed = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; lastw = '0;
    @(negedge clk);
    run = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    drive_word(0, nw);
    #1 check("in_ready_during_run", in_ready, 1'b0);
    @(negedge clk);
    run = 1'b0;
    while (cyc < 4000) begin
      cyc++;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : ($urandom_range(0, 2) != 0);
      if (wi < nw) begin
        in_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        drive_word(wi, nw);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && prev_stall) check("stall_hold", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("extra_word", 1'b1, 1'b0);
        end else begin
          e = expq.pop_front();
          check($sformatf("word%0d", consumed), {out_data, out_first, out_last_blk},
                {e.data, e.first, e.last});
        end
        consumed++;
        lastw = out_data;
      end
      if (in_valid && in_ready) wi++;
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      if (abort_after > 0 && consumed == abort_after) break;
      if (expq.size() == 0) break;
      @(negedge clk);
    end
    nwords = consumed;
    if (abort_after == 0) begin
      if (expq.size() != 0) check("timeout", 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check("done_after_last", {done, out_valid}, 2'b10);
    end
  endtask

  function automatic void load_msg(input int len, input bit abc, input bit rnd);
    msg.delete();
    for (int i = 0; i < len; i++)
      msg.push_back(abc ? 8'(8'h61 + i) : rnd ? 8'($urandom) : 8'(i));
  endfunction

  vec_t        tv[8];
  int          nwords, len;
  logic [31:0] lastw;

  initial begin
    rst = 1'b1; run = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_bytes = '0;
    in_data = '0; out_ready = 1'b0;
    #12;
    check("reset_outputs", {out_valid, in_ready, done, out_first, out_last_blk, out_data},
          '0);
    @(negedge clk);
    rst = 1'b0;

    tv[0] = '{3,  1'b1, 0, 16, 32'h18};
    tv[1] = '{0,  1'b0, 0, 16, 32'h0};
    tv[2] = '{56, 1'b0, 0, 32, 32'h1C0};
    tv[3] = '{64, 1'b0, 0, 32, 32'h200};
    tv[4] = '{56, 1'b0, 1, 32, 32'h1C0};
    tv[5] = '{55, 1'b0, 2, 16, 32'h1B8};
    tv[6] = '{63, 1'b0, 1, 32, 32'h1F8};
    tv[7] = '{4,  1'b0, 2, 16, 32'h20};
    for (int t = 0; t < 8; t++) begin
      load_msg(tv[t].len, tv[t].abc, 1'b0);
      run_msg(tv[t].mode, 0, nwords, lastw);
      check($sformatf("vec%0d_words", t), 64'(nwords), 64'(tv[t].exp_words));
      check($sformatf("vec%0d_lenword", t), lastw, tv[t].exp_last);
    end

    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(0, 140);
      load_msg(len, 1'b0, 1'b1);
      run_msg(2, 0, nwords, lastw);
      check($sformatf("rnd%0d_words", r), 64'(nwords), 64'(((len + 9 + 63) / 64) * 16));
      check($sformatf("rnd%0d_lenword", r), lastw, 32'(len * 8));
    end

    // asynchronous reset in the middle of a block
    load_msg(40, 1'b0, 1'b0);
    run_msg(0, 5, nwords, lastw);
    rst = 1'b1;
    #1 check("async_rst", {out_valid, in_ready, done}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    load_msg(3, 1'b1, 1'b0);
    run_msg(0, 0, nwords, lastw);
    check("abc_after_rst_words", 64'(nwords), 64'd16);

    // run aborting a message mid-stream, then a clean message
    load_msg(90, 1'b0, 1'b1);
    run_msg(2, 9, nwords, lastw);
    load_msg(3, 1'b1, 1'b0);
    run_msg(1, 0, nwords, lastw);
    check("abc_after_run_abort", lastw, 32'h18);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
